// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage: ready/valid accept, fixed wait states, one-cycle response.
// Optional misalignment detection (AlignErr port) is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic [1:0]  MemWrite,
    input  logic [1:0]  MemRead,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        RespValid,
    output logic [31:0] ReadData,
    output logic        Stall
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic        AlignErr
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_cnt;
    logic [1:0]  r_wr;
    logic [1:0]  r_rd;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_misalign;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_mem_q;

    logic        w_req_nz;
    logic        w_accept;
    logic        w_go_resp;
    logic        w_in_misalign;
    logic [1:0]  w_op_wr;
    logic [31:0] w_op_addr;
    logic [31:0] w_op_wdata;
    logic        w_op_misalign;
    logic [AW-1:0] w_op_idx;
    logic [3:0]  w_be;
    logic [31:0] w_wlanes;
    logic        w_we;
    logic [31:0] w_rd_sel;

    assign w_req_nz = (MemWrite != 2'b00) || (MemRead != 2'b00);

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] w_in_size;
    assign w_in_size     = (MemWrite != 2'b00) ? MemWrite : MemRead;
    assign w_in_misalign = ((w_in_size == 2'b10) && Address[0]) ||
                           ((w_in_size == 2'b01) && (Address[1:0] != 2'b00));
    assign AlignErr      = (r_state == S_RESP) && r_misalign;
`else
    assign w_in_misalign = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        ReqReady     = 1'b0;
        Stall        = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                ReqReady = Reset;
                if (ReqValid && w_req_nz) begin
                    Stall        = Reset;
                    w_accept     = Reset;
                    w_state_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                Stall = Reset;
                if (r_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_cnt      <= 4'd0;
            r_wr       <= 2'b00;
            r_rd       <= 2'b00;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_misalign <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= CNT_INIT;
            r_wr       <= MemWrite;
            r_rd       <= MemRead;
            r_addr     <= Address;
            r_wdata    <= WriteData;
            r_misalign <= w_in_misalign;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // The array is touched on the edge that enters RESP; with no wait states that is the accept edge,
    // so the operation comes straight from the inputs instead of the latched copy.
    assign w_go_resp     = Reset && (w_state_next == S_RESP);
    assign w_op_wr       = (r_state == S_IDLE) ? MemWrite      : r_wr;
    assign w_op_addr     = (r_state == S_IDLE) ? Address       : r_addr;
    assign w_op_wdata    = (r_state == S_IDLE) ? WriteData     : r_wdata;
    assign w_op_misalign = (r_state == S_IDLE) ? w_in_misalign : r_misalign;
    assign w_op_idx      = w_op_addr[AW+1:2];

    // Big-endian lanes: byte offset 0 lives in bits [31:24].
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = w_op_wdata;
        case (w_op_wr)
            2'b01: w_be = 4'b1111;
            2'b10: begin
                w_be     = w_op_addr[1] ? 4'b0011 : 4'b1100;
                w_wlanes = {2{w_op_wdata[15:0]}};
            end
            2'b11: begin
                w_be     = 4'b1000 >> w_op_addr[1:0];
                w_wlanes = {4{w_op_wdata[7:0]}};
            end
            default: w_be = 4'b0000;
        endcase
    end

    assign w_we = w_go_resp && (w_op_wr != 2'b00) && !w_op_misalign;

    always_ff @(posedge Clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && w_be[i]) begin
                r_mem[w_op_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
        if (w_go_resp) begin
            r_mem_q <= r_mem[w_op_idx];
        end
    end

    always_comb begin
        w_rd_sel = 32'd0;
        case (r_rd)
            2'b01: w_rd_sel = r_mem_q;
            2'b10: w_rd_sel = r_addr[1] ? {16'd0, r_mem_q[15:0]} : {16'd0, r_mem_q[31:16]};
            2'b11: begin
                case (r_addr[1:0])
                    2'b00:   w_rd_sel = {24'd0, r_mem_q[31:24]};
                    2'b01:   w_rd_sel = {24'd0, r_mem_q[23:16]};
                    2'b10:   w_rd_sel = {24'd0, r_mem_q[15:8]};
                    default: w_rd_sel = {24'd0, r_mem_q[7:0]};
                endcase
            end
            default: w_rd_sel = 32'd0;
        endcase
    end

    assign RespValid = (r_state == S_RESP);
    // A store (even when combined with a load code) or a rejected misaligned access returns zero.
    assign ReadData  = ((r_state == S_RESP) && (r_wr == 2'b00) && !r_misalign) ? w_rd_sel : 32'd0;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface.
- The pipeline issues a load/store request (Address, WriteData, and 2-bit MemWrite/MemRead size codes). This block accepts it with a ready/valid handshake, inserts a programmable number of wait states, then commits the write or returns the read data.
- It raises Stall so the pipeline can hold IF/ID/EX/MEM while the access is outstanding.
- It replaces the zero-latency data memory for multi-cycle memory modelling.

Parameters:
- DEPTH_WORDS, 1024: backing store size in 32-bit words (power of two); index = Address[log2(DEPTH_WORDS)+1:2].
- WAIT_STATES, 2: cycles spent in WAIT before the response (0..15).

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low reset.
- ReqValid  in  1  request present from MEM stage.
- ReqReady  out  1  responder can accept a request this cycle.
- MemWrite  in  2  store size: 00 none, 01 word, 10 half, 11 byte.
- MemRead  in  2  load size, same encoding.
- Address  in  32  byte address.
- WriteData  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- RespValid  out  1  one-cycle pulse: access complete.
- ReadData  out  32  load result, zero-extended; valid when RespValid=1.
- Stall  out  1  hold-pipeline request.

Behaviour:
- **Clock and reset (already decided):** one clock, Clk. Reset is synchronous and active-low.
- **Reset (Reset=0 at a rising edge):**
  - State goes to IDLE; RespValid=0, ReadData=0, Stall=0.
  - ReqReady=0 while Reset=0.
  - Any latched request is discarded and a pending write is NOT committed.
  - Memory contents are preserved, not cleared.
- **States:** IDLE, WAIT, RESP.
- **IDLE:**
  - ReqReady=1.
  - A request is accepted when ReqValid=1 and (MemWrite!=00 or MemRead!=00); Address, WriteData and the size codes are latched.
  - ReqValid with both codes 00 is ignored and the state stays IDLE.
  - On acceptance: next state is WAIT if WAIT_STATES>0, else RESP. The wait counter loads WAIT_STATES-1.
- **WAIT:**
  - ReqReady=0; the counter decrements each cycle.
  - At count 0 the next state is RESP.
  - The write is committed to the array on the edge leaving WAIT (or on the accept edge when WAIT_STATES=0).
- **RESP:**
  - RespValid=1 for exactly one cycle; ReadData is registered.
  - ReqReady=0; the next state is always IDLE.
  - A new request can be accepted in the IDLE cycle immediately after.
- **Latency:** RespValid is asserted exactly WAIT_STATES+1 cycles after the accepting edge.
- **Stall:**
  - Stall = (IDLE and ReqValid and request nonzero) or WAIT. This is combinational on inputs in IDLE.
  - Stall=0 in RESP, so the pipeline advances on the response cycle.
- **Byte lanes (big-endian):**
  - Byte select Address[1:0]: 00→[31:24], 01→[23:16], 10→[15:8], 11→[7:0].
  - Half select Address[1]: 0→[31:16], 1→[15:0].
  - Writes update only the selected lanes.
  - Reads return the selected lanes right-justified, upper bits 0.
- **Simultaneous read and write codes:** write wins, the read is ignored, and ReadData=0 in RESP.
- **Address range:** bits above the index wrap (modulo DEPTH_WORDS).
- **Misalignment (feature off):** half ignores Address[0]; word ignores Address[1:0].
- **Request changes:** changes on request inputs after acceptance are ignored until IDLE.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined:
  - Adds output port AlignErr (out, 1).
  - A misaligned request is still accepted and waits normally. Misaligned means half with Address[0]=1, or word with Address[1:0]!=00.
  - In RESP, AlignErr=1 together with RespValid, the write is suppressed, and ReadData=0.
  - AlignErr resets to 0.
- When not defined: no AlignErr port, and the low address bits are ignored as described above.

Test Plan:
- Reset=0 for 2 cycles, then 1 → ReqReady 0 during reset, 1 in the first IDLE cycle; RespValid=0, Stall=0.
- WAIT_STATES=2: word store 0xDEADBEEF @0x10, then word load @0x10 → each RespValid exactly 3 cycles after accept; load ReadData=0xDEADBEEF; Stall high for 3 cycles per access.
- Byte store 0xAB @0x13, then word load @0x10 → 0xDEADBEAB; half load @0x12 → 0x0000BEAB; byte load @0x10 → 0x000000DE.
- WAIT_STATES=0: back-to-back word loads → RespValid one cycle after each accept; ReqReady 1,0,1,0 pattern; ReqValid with codes 00 → no RespValid.
- Store accepted, Reset=0 during WAIT → no RespValid; a subsequent load shows the old data unchanged.
- With DMEM_ALIGN_CHECK_EN: word store @0x11 → AlignErr=1 with RespValid; memory unchanged; aligned access → AlignErr=0.
